// File: rtl/tdm_demux.sv
// tdm_demux: TDM stream demultiplexer that steers slot samples into lanes and publishes whole frames
module tdm_demux #(
   parameter int N_SLOTS = 8,
   parameter int SEL_W   = 3,
   parameter int WIDTH   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     din_valid,
   input  logic [WIDTH-1:0]         din,
   input  logic                     frame_sync,
   output logic [N_SLOTS*WIDTH-1:0] dout,
   output logic                     frame_valid,
   output logic [SEL_W-1:0]         slot,
   output logic                     locked,
   output logic                     sync_err
);
   typedef enum logic {HUNT, LOCKED} state_t;
   state_t state;
   // the last lane goes straight from din into dout, so staging only holds lanes 0..N_SLOTS-2
   logic [(N_SLOTS-1)*WIDTH-1:0] staging;
   logic last;
   assign last = slot == SEL_W'(N_SLOTS-1);
   // framing FSM: hunt for sync, fill lanes in order, publish on the final slot, flag violations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         slot        <= '0;
         dout        <= '0;
         staging     <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (din_valid) begin
            if (state == HUNT) begin
               if (frame_sync) begin
                  staging[0 +: WIDTH] <= din;
                  slot   <= SEL_W'(1);
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end else if (frame_sync) begin
               staging[0 +: WIDTH] <= din;
               slot     <= SEL_W'(1);
               sync_err <= slot != '0;
            end else if (slot == '0) begin
               sync_err <= 1'b1;
               state    <= HUNT;
               locked   <= 1'b0;
            end else if (last) begin
               dout        <= {din, staging};
               frame_valid <= 1'b1;
               slot        <= '0;
            end else begin
               staging[slot*WIDTH +: WIDTH] <= din;
               slot <= slot + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed spec scenarios plus randomized beats against a queue-based frame model
module tb_tdm_demux;
   localparam int N = 8, SW = 3, W = 1;
   logic clk = 1'b0, rst_n = 1'b1, din_valid = 1'b0, frame_sync = 1'b0;
   logic [W-1:0] din = '0;
   logic [N*W-1:0] dout;
   logic frame_valid, locked, sync_err;
   logic [SW-1:0] slot;
   int errors = 0, checks = 0;
   logic m_locked = 1'b0, m_fv = 1'b0, m_err = 1'b0;
   logic [N*W-1:0] m_dout = '0;
   logic [W-1:0] m_q[$];

   tdm_demux #(.N_SLOTS(N), .SEL_W(SW), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .frame_sync(frame_sync),
      .dout(dout), .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_locked = 1'b0; m_fv = 1'b0; m_err = 1'b0; m_dout = '0; m_q = {};
   endtask

   // frame-level model: current frame is a queue of samples, published when it holds N entries
   task automatic mdl(input logic v, input logic s, input logic [W-1:0] d);
      m_fv = 1'b0; m_err = 1'b0;
      if (!v) return;
      if (!m_locked) begin
         if (s) begin m_q = {d}; m_locked = 1'b1; end
      end else if (s) begin
         m_err = m_q.size() != 0; m_q = {d};
      end else if (m_q.size() == 0) begin
         m_err = 1'b1; m_locked = 1'b0;
      end else begin
         m_q.push_back(d);
         if (m_q.size() == N) begin
            for (int k = 0; k < N; k++) m_dout[k*W +: W] = m_q[k];
            m_fv = 1'b1; m_q = {};
         end
      end
   endtask

   task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
      @(negedge clk); din_valid = v; frame_sync = s; din = d;
      @(posedge clk); #1;
      mdl(v, s, d);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_reset();
   endtask

   task automatic send_frame(input logic [N-1:0] bits);
      for (int k = 0; k < N; k++) beat(1'b1, k == 0, bits[k]);
   endtask

   task automatic test_reset();
      din_valid = 1'b1; frame_sync = 1'b1; din = 1'b0;
      #1 din = 1'b1;
      #1 din = 1'b0;
      #1 rst_n = 1'b0; din = 1'b1;
      #1;
      checks++;
      if ({dout, frame_valid, locked, slot, sync_err} !== '0) begin
         errors++;
         $display("FAIL reset: dout=%b fv=%b locked=%b slot=%0d err=%b, want all zero", dout, frame_valid, locked, slot, sync_err);
      end
      @(negedge clk); din_valid = 1'b0; frame_sync = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_frame();
      send_frame(8'b10101010);
      checks++;
      if (dout !== 8'b10101010 || frame_valid !== 1'b1 || locked !== 1'b1 || slot !== 3'd0) begin
         errors++;
         $display("FAIL frame: dout=%b fv=%b locked=%b slot=%0d, want 10101010 1 1 0", dout, frame_valid, locked, slot);
      end
      beat(1'b0, 1'b0, 1'b0);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL frame_pulse: fv=%b, want 0", frame_valid); end
   endtask

   task automatic test_gaps();
      logic [N-1:0] bits = 8'b10101010;
      logic seen = 1'b0;
      for (int k = 0; k < N; k++) begin
         beat(1'b1, k == 0, bits[k]);
         seen |= frame_valid && k < N-1;
         if (k == 2 || k == 6) begin
            for (int g = 0; g < (k == 2 ? 3 : 1); g++) begin
               beat(1'b0, 1'b0, 1'b1);
               seen |= frame_valid;
               checks++;
               if (slot !== SW'(k+1)) begin errors++; $display("FAIL gap_slot: slot=%0d, want %0d", slot, k+1); end
            end
         end
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL gap_early_fv: early frame_valid=%b, want 0", seen); end
      checks++;
      if (dout !== 8'b10101010 || frame_valid !== 1'b1) begin
         errors++; $display("FAIL gap_frame: dout=%b fv=%b, want 10101010 1", dout, frame_valid);
      end
   endtask

   task automatic test_hunt();
      logic seen = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         beat(1'b1, 1'b0, 1'b1);
         seen |= locked | frame_valid | sync_err;
      end
      checks++;
      if (seen !== 1'b0 || slot !== 3'd0) begin
         errors++; $display("FAIL hunt_ignore: activity=%b slot=%0d, want 0 0", seen, slot);
      end
      send_frame(8'b00001111);
      checks++;
      if (dout !== 8'b00001111 || frame_valid !== 1'b1) begin
         errors++; $display("FAIL hunt_frame: dout=%b fv=%b, want 00001111 1", dout, frame_valid);
      end
   endtask

   task automatic test_early_sync();
      for (int k = 0; k < 5; k++) beat(1'b1, k == 0, 1'b0);
      beat(1'b1, 1'b1, 1'b1);
      checks++;
      if (sync_err !== 1'b1 || frame_valid !== 1'b0 || dout !== 8'b00001111 || slot !== 3'd1 || locked !== 1'b1) begin
         errors++;
         $display("FAIL early_sync: err=%b fv=%b dout=%b slot=%0d locked=%b, want 1 0 00001111 1 1", sync_err, frame_valid, dout, slot, locked);
      end
      for (int k = 1; k < N; k++) begin
         beat(1'b1, 1'b0, 1'b1);
         if (k == 1) begin
            checks++;
            if (sync_err !== 1'b0) begin errors++; $display("FAIL err_pulse: err=%b, want 0", sync_err); end
         end
      end
      checks++;
      if (dout !== 8'hFF || frame_valid !== 1'b1) begin
         errors++; $display("FAIL early_refill: dout=%h fv=%b, want ff 1", dout, frame_valid);
      end
   endtask

   task automatic test_missing_sync();
      beat(1'b1, 1'b0, 1'b1);
      checks++;
      if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 3'd0 || dout !== 8'hFF) begin
         errors++; $display("FAIL missing_sync: err=%b locked=%b slot=%0d dout=%h, want 1 0 0 ff", sync_err, locked, slot, dout);
      end
      send_frame(8'b10000001);
      checks++;
      if (dout !== 8'b10000001 || frame_valid !== 1'b1 || locked !== 1'b1) begin
         errors++; $display("FAIL resync: dout=%b fv=%b locked=%b, want 10000001 1 1", dout, frame_valid, locked);
      end
      for (int k = 0; k < 4; k++) beat(1'b1, k == 0, 1'b1);
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== '0 || locked !== 1'b0 || slot !== 3'd0) begin
         errors++; $display("FAIL mid_reset: dout=%b locked=%b slot=%0d, want 0 0 0", dout, locked, slot);
      end
      @(negedge clk); rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      logic v, s;
      for (int i = 0; i < 600; i++) begin
         v = $urandom_range(0, 9) < 7;
         s = (m_q.size() == 0) ? $urandom_range(0, 9) < 8 : $urandom_range(0, 19) == 0;
         beat(v, s, W'($urandom));
         checks++;
         if ({dout, frame_valid, sync_err, locked, slot} !== {m_dout, m_fv, m_err, m_locked, SW'(m_q.size())}) begin
            errors++;
            $display("FAIL random[%0d]: dout=%b fv=%b err=%b locked=%b slot=%0d, want %b %b %b %b %0d",
                     i, dout, frame_valid, sync_err, locked, slot, m_dout, m_fv, m_err, m_locked, m_q.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_gaps();
      test_hunt();
      test_early_sync();
      test_missing_sync();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
